// File: rtl/alu_issue.sv
// ALU issue stage: decodes ALU select/operands and buffers beats in a
// two-entry skid buffer (output entry O plus skid entry S).
`default_nettype none

module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm16,
  input  logic        alu_src,
  input  logic [4:0]  dest_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  dest_out
);

  localparam int PW = 73;

  logic [3:0]    dec_sel;
  logic [31:0]   dec_b;
  logic [PW-1:0] in_word;
  logic [PW-1:0] o_data, s_data, o_data_nx, s_data_nx;
  logic          o_valid, s_valid, rdy;
  logic          o_valid_nx, s_valid_nx;
  logic          acc, iss;

  always_comb begin
    dec_sel = 4'b1000;
    case (alu_op)
      2'b00: dec_sel = 4'b0010;
      2'b01: dec_sel = 4'b0110;
      2'b11: dec_sel = 4'b0001;
      default: begin
        case (funct)
          6'b100000: dec_sel = 4'b0010;
          6'b100010: dec_sel = 4'b0110;
          6'b100100: dec_sel = 4'b0000;
          6'b100101: dec_sel = 4'b0001;
          6'b100110: dec_sel = 4'b1110;
          6'b100111: dec_sel = 4'b1111;
          6'b101010: dec_sel = 4'b0111;
          default:   dec_sel = 4'b1000;
        endcase
      end
    endcase
  end

  // OR-immediate zero-extends; every other immediate form sign-extends.
  always_comb begin
    dec_b = rt_data;
    if (alu_src) begin
      if (alu_op == 2'b11) dec_b = {16'h0000, imm16};
      else                 dec_b = {{16{imm16[15]}}, imm16};
    end
  end

  assign in_word = {dec_sel, rs_data, dec_b, dest_in};
  assign acc     = in_valid & rdy;
  assign iss     = o_valid & out_ready;

  always_comb begin
    o_valid_nx = o_valid;
    s_valid_nx = s_valid;
    o_data_nx  = o_data;
    s_data_nx  = s_data;
    if (flush) begin
      o_valid_nx = 1'b0;
      s_valid_nx = 1'b0;
    end else if (iss && s_valid) begin
      o_data_nx  = s_data;
      s_valid_nx = 1'b0;
    end else if (acc && (!o_valid || iss)) begin
      o_data_nx  = in_word;
      o_valid_nx = 1'b1;
    end else if (acc) begin
      s_data_nx  = in_word;
      s_valid_nx = 1'b1;
    end else if (iss) begin
      o_valid_nx = 1'b0;
    end
  end

  // rdy mirrors !s_valid but stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy     <= 1'b0;
      o_data  <= '0;
      s_data  <= '0;
    end else begin
      o_valid <= o_valid_nx;
      s_valid <= s_valid_nx;
      rdy     <= ~s_valid_nx;
      o_data  <= o_data_nx;
      s_data  <= s_data_nx;
    end
  end

  assign in_ready  = rdy;
  assign out_valid = o_valid;
  assign {alu_sel, alu_a, alu_b, dest_out} = o_data;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// Directed scoreboard bench for alu_issue.
`default_nettype none

module tb_alu_issue;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, alu_src, out_valid, out_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data, alu_a, alu_b;
  logic [15:0] imm16;
  logic [4:0]  dest_in, dest_out;
  logic [3:0]  alu_sel;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  logic  mrdy;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16), .alu_src(alu_src), .dest_in(dest_in), .out_valid(out_valid),
    .out_ready(out_ready), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  function automatic beat_t model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [15:0] imm, input logic src, input logic [4:0] d);
    beat_t r;
    r.a = rs;
    r.d = d;
    case (op)
      2'b00: r.sel = 4'b0010;
      2'b01: r.sel = 4'b0110;
      2'b11: r.sel = 4'b0001;
      default:
        case (fn)
          6'h20: r.sel = 4'b0010;
          6'h22: r.sel = 4'b0110;
          6'h24: r.sel = 4'b0000;
          6'h25: r.sel = 4'b0001;
          6'h26: r.sel = 4'b1110;
          6'h27: r.sel = 4'b1111;
          6'h2A: r.sel = 4'b0111;
          default: r.sel = 4'b1000;
        endcase
    endcase
    if (!src)            r.b = rt;
    else if (op == 2'b11) r.b = {16'h0, imm};
    else                 r.b = {{16{imm[15]}}, imm};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check and update the model at negedge.
  task automatic step(input logic iv, input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input logic src, input logic [4:0] d, input logic ordy, input logic fl);
    logic acc, iss;
    in_valid = iv; alu_op = op; funct = fn; rs_data = rs; rt_data = rt;
    imm16 = imm; alu_src = src; dest_in = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, mrdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
    if (q.size() > 0) begin
      chk("alu_sel", {28'b0, alu_sel}, {28'b0, q[0].sel});
      chk("alu_a", alu_a, q[0].a);
      chk("alu_b", alu_b, q[0].b);
      chk("dest_out", {27'b0, dest_out}, {27'b0, q[0].d});
    end
    if (fl) begin
      q.delete();
    end else begin
      iss = (q.size() > 0) && ordy;
      acc = iv && mrdy;
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(model(op, fn, rs, rt, imm, src, d));
    end
    mrdy = (q.size() < 2);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct = 6'h0; rs_data = '0; rt_data = '0;
    imm16 = '0; alu_src = 1'b0; dest_in = '0;
    mrdy = 1'b0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_alu_sel", {28'b0, alu_sel}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_dest", {27'b0, dest_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b1);

    // Scenario 1: slt R-type
    step(1'b1, 2'b10, 6'b101010, 32'd5, 32'd9, 16'h0, 1'b0, 5'd3, 1'b1, 1'b0);
    // Scenario 2: add-immediate sign extension, then OR-immediate zero extension
    step(1'b1, 2'b00, 6'h0, 32'h11, 32'h0, 16'hFFFC, 1'b1, 5'd4, 1'b1, 1'b0);
    step(1'b1, 2'b11, 6'h0, 32'h22, 32'h0, 16'hFFFC, 1'b1, 5'd5, 1'b1, 1'b0);
    // Scenario 4 plus remaining funct codes and sub, back to back
    step(1'b1, 2'b10, 6'b000000, 32'h1, 32'h2, 16'h0, 1'b0, 5'd6, 1'b1, 1'b0);
    step(1'b1, 2'b10, 6'h20, 32'h3, 32'h4, 16'h0, 1'b0, 5'd7, 1'b1, 1'b0);
    step(1'b1, 2'b10, 6'h22, 32'h5, 32'h6, 16'h0, 1'b0, 5'd8, 1'b1, 1'b0);
    step(1'b1, 2'b10, 6'h24, 32'h7, 32'h8, 16'h0, 1'b0, 5'd9, 1'b1, 1'b0);
    step(1'b1, 2'b10, 6'h25, 32'h9, 32'hA, 16'h0, 1'b0, 5'd10, 1'b1, 1'b0);
    step(1'b1, 2'b10, 6'h26, 32'hB, 32'hC, 16'h0, 1'b0, 5'd11, 1'b1, 1'b0);
    step(1'b1, 2'b10, 6'h27, 32'hD, 32'hE, 16'h0, 1'b0, 5'd12, 1'b1, 1'b0);
    step(1'b1, 2'b01, 6'h0, 32'h10, 32'h0, 16'h8001, 1'b1, 5'd13, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Scenario 3: stall with A, B, C then drain in order
    step(1'b1, 2'b00, 6'h0, 32'hA0, 32'hA1, 16'h0, 1'b0, 5'd1, 1'b0, 1'b0);
    step(1'b1, 2'b01, 6'h0, 32'hB0, 32'hB1, 16'h0, 1'b0, 5'd2, 1'b0, 1'b0);
    step(1'b1, 2'b11, 6'h0, 32'hC0, 32'hC1, 16'h1234, 1'b1, 5'd3, 1'b0, 1'b0);
    step(1'b1, 2'b11, 6'h0, 32'hC0, 32'hC1, 16'h1234, 1'b1, 5'd3, 1'b0, 1'b0);
    step(1'b1, 2'b11, 6'h0, 32'hC0, 32'hC1, 16'h1234, 1'b1, 5'd3, 1'b1, 1'b0);
    step(1'b1, 2'b11, 6'h0, 32'hC0, 32'hC1, 16'h1234, 1'b1, 5'd3, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Scenario 5: fill O and S, flush with a beat offered
    step(1'b1, 2'b00, 6'h0, 32'h51, 32'h0, 16'h0, 1'b0, 5'd21, 1'b0, 1'b0);
    step(1'b1, 2'b00, 6'h0, 32'h52, 32'h0, 16'h0, 1'b0, 5'd22, 1'b0, 1'b0);
    step(1'b1, 2'b00, 6'h0, 32'h53, 32'h0, 16'h0, 1'b0, 5'd23, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Scenario 6: async reset between edges while O holds a beat
    step(1'b1, 2'b10, 6'h26, 32'h61, 32'h62, 16'h0, 1'b0, 5'd30, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_alu_sel", {28'b0, alu_sel}, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_dest", {27'b0, dest_out}, 32'd0);
    q.delete();
    mrdy = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 2'b10, 6'h25, 32'h71, 32'h72, 16'h0, 1'b0, 5'd31, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL use port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 The block SHALL use port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL use port flush, input, 1 bit: synchronous pipeline flush.
REQ-004 The block SHALL use port in_valid, input, 1 bit: upstream beat valid.
REQ-005 The block SHALL use port in_ready, output, 1 bit: block can accept a beat.
REQ-006 The block SHALL use port alu_op, input, 2 bits: 00 add, 01 sub, 10 R-type (use funct), 11 OR-immediate.
REQ-007 The block SHALL use port funct, input, 6 bits: R-type function field.
REQ-008 The block SHALL use ports rs_data and rt_data, inputs, 32 bits each: register-file read data.
REQ-009 The block SHALL use port imm16, input, 16 bits: instruction immediate.
REQ-010 The block SHALL use port alu_src, input, 1 bit: 1 selects extended immediate as operand B, 0 selects rt_data.
REQ-011 The block SHALL use port dest_in, input, 5 bits: destination register number, carried through.
REQ-012 The block SHALL use port out_valid, output, 1 bit: issued beat valid toward the ALU.
REQ-013 The block SHALL use port out_ready, input, 1 bit: downstream accepts the beat.
REQ-014 The block SHALL use port alu_sel, output, 4 bits: ALU operation code.
REQ-015 The block SHALL use ports alu_a and alu_b, outputs, 32 bits each: ALU operands.
REQ-016 The block SHALL use port dest_out, output, 5 bits: carried destination.

Function
REQ-017 The block SHALL accept a beat when in_valid and in_ready are both 1 at a clock edge, and SHALL issue one when out_valid and out_ready are both 1.
REQ-018 The block SHALL decode alu_sel at acceptance as follows: alu_op 00 gives 0010; 01 gives 0110; 11 gives 0001.
REQ-019 For alu_op 10, the block SHALL map funct as: 100000 to 0010, 100010 to 0110, 100100 to 0000, 100101 to 0001, 100110 to 1110, 100111 to 1111, 101010 to 0111, and any other value to 1000 (unsupported; ALU yields 0).
REQ-020 The block SHALL set alu_a to rs_data.
REQ-021 The block SHALL set alu_b to rt_data when alu_src is 0; otherwise it SHALL use imm16 zero-extended when alu_op is 11, and sign-extended in all other cases.
REQ-022 The block SHALL hold two registered entries, an output entry O driving the outputs and a skid entry S, each with its own valid bit.
REQ-023 in_ready SHALL equal NOT S.valid, driven directly from a register with no combinational path from out_ready.
REQ-024 On acceptance, the beat SHALL load O if O is empty or O issues in the same cycle; otherwise it SHALL load S.
REQ-025 When O issues and S is valid, S SHALL move into O and S SHALL become empty in the same edge.
REQ-026 Latency from acceptance into an empty block to out_valid SHALL be exactly 1 cycle.
REQ-027 Throughput SHALL be one beat per cycle while out_ready is held at 1.
REQ-028 While out_valid is 1 and out_ready is 0, O contents SHALL remain stable.
REQ-029 Beats SHALL issue in acceptance order, with none lost or duplicated.
REQ-030 flush SHALL clear O.valid and S.valid at the next edge, and any input handshake in the flush cycle SHALL be discarded; flush has priority over all other updates.

Reset
REQ-031 While rst_n is 0, the block SHALL force O.valid=0, S.valid=0, out_valid=0, in_ready=0, alu_sel=0000, alu_a=0, alu_b=0 and dest_out=0, regardless of clk.
REQ-032 in_ready SHALL rise at the first clock edge after rst_n is released.
REQ-033 Reset asserted mid-transfer SHALL discard all held beats.

Verification
REQ-034 Scenario 1: alu_op=10, funct=101010, rs=5, rt=9, alu_src=0, dest=3, out_ready=1 -> next cycle out_valid=1, alu_sel=0111, alu_a=5, alu_b=9, dest_out=3.
REQ-035 Scenario 2: alu_op=00, alu_src=1, imm16=0xFFFC -> alu_sel=0010, alu_b=0xFFFFFFFC; repeat with alu_op=11 -> alu_sel=0001, alu_b=0x0000FFFC.
REQ-036 Scenario 3: out_ready=0, stream beats A, B, C -> A held in O, B in S, in_ready=0 and C not accepted; out_ready=1 -> A, B, C issue in order on consecutive cycles.
REQ-037 Scenario 4: alu_op=10, funct=000000 -> alu_sel=1000.
REQ-038 Scenario 5: O and S full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no beat issues later.
REQ-039 Scenario 6: rst_n driven low between clock edges while O is valid -> out_valid=0 immediately; after release, first accepted beat appears 1 cycle later.
